// File: rtl/morse_pkg.sv
// Morse sequencer shared types: state enum, code constants, unit counts and the letter pattern table.
// Patterns are left-aligned in 4 bits (element 0 at bit 3), 1 = dash, 0 = dot.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        SPACE,
        LGAP,
        WGAP
    } morse_state_t;

    localparam logic [4:0] MORSE_SPACE       = 5'd26;
    localparam logic [4:0] MORSE_LAST_LETTER = 5'd25;

    localparam int MORSE_DOT_U  = 1;
    localparam int MORSE_DASH_U = 3;
    localparam int MORSE_LGAP_U = 3;
    localparam int MORSE_WGAP_U = 4;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] bits;
    } morse_pat_t;

    function automatic morse_pat_t morse_lookup(input logic [4:0] code);
        morse_pat_t p;
        case (code)
            5'd0:    p = {3'd2, 4'b0100};  // A .-
            5'd1:    p = {3'd4, 4'b1000};  // B -...
            5'd2:    p = {3'd4, 4'b1010};  // C -.-.
            5'd3:    p = {3'd3, 4'b1000};  // D -..
            5'd4:    p = {3'd1, 4'b0000};  // E .
            5'd5:    p = {3'd4, 4'b0010};  // F ..-.
            5'd6:    p = {3'd3, 4'b1100};  // G --.
            5'd7:    p = {3'd4, 4'b0000};  // H ....
            5'd8:    p = {3'd2, 4'b0000};  // I ..
            5'd9:    p = {3'd4, 4'b0111};  // J .---
            5'd10:   p = {3'd3, 4'b1010};  // K -.-
            5'd11:   p = {3'd4, 4'b0100};  // L .-..
            5'd12:   p = {3'd2, 4'b1100};  // M --
            5'd13:   p = {3'd2, 4'b1000};  // N -.
            5'd14:   p = {3'd3, 4'b1110};  // O ---
            5'd15:   p = {3'd4, 4'b0110};  // P .--.
            5'd16:   p = {3'd4, 4'b1101};  // Q --.-
            5'd17:   p = {3'd3, 4'b0100};  // R .-.
            5'd18:   p = {3'd3, 4'b0000};  // S ...
            5'd19:   p = {3'd1, 4'b1000};  // T -
            5'd20:   p = {3'd3, 4'b0010};  // U ..-
            5'd21:   p = {3'd4, 4'b0001};  // V ...-
            5'd22:   p = {3'd3, 4'b0110};  // W .--
            5'd23:   p = {3'd4, 4'b1001};  // X -..-
            5'd24:   p = {3'd4, 4'b1011};  // Y -.--
            5'd25:   p = {3'd4, 4'b1100};  // Z --..
            default: p = {3'd0, 4'b0000};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous FIFO: write visible to the reader one cycle after push; rd_dat is the head, shown combinationally.
// Backpressure via registered full; pushes while full are ignored, flush empties it on the next edge.
module morse_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full_q && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        full_d = ((wr_ptr_d - rd_ptr_d) == FULL_CNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign full   = full_q;
    assign count  = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/morse_sequencer.sv
// Morse playback scheduler: queued letter codes become timed buzz marks; first mark 2 cycles after the write.
// char_ready drops while the queue is full (overflow pulse on a refused offer); MORSE_SEQ_ABORT_EN adds an abort input.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 2500000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          char_valid,
    input  logic [4:0]                    char_code,
    output logic                          char_ready,
    output logic                          overflow,
    output logic                          buzz,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef MORSE_SEQ_ABORT_EN
    ,
    input  logic                          abort
`endif
);
    import morse_pkg::*;

    localparam int CW = $clog2(UNIT_CYCLES);

    morse_state_t  state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    units_q, units_d;
    morse_pat_t    pat_q, pat_d;
    logic [1:0]    idx_q, idx_d;
    logic          buzz_q, buzz_d, ovf_q, ovf_d;
    logic          abort_w, push, pop, full, empty;
    logic          unit_end, interval_done;
    logic [2:0]    dur;
    logic [4:0]    head;

`ifdef MORSE_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign push  = char_valid && !full && !abort_w;
    assign ovf_d = char_valid && full && !abort_w;

    morse_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(5)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (abort_w),
        .wr_dat (char_code),
        .rd_dat (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    always_comb begin
        case (state_q)
            MARK:    dur = pat_q.bits[2'd3 - idx_q] ? 3'(MORSE_DASH_U) : 3'(MORSE_DOT_U);
            LGAP:    dur = 3'(MORSE_LGAP_U);
            WGAP:    dur = 3'(MORSE_WGAP_U);
            default: dur = 3'(MORSE_DOT_U);
        endcase
    end

    assign unit_end      = (cyc_q == CW'(UNIT_CYCLES - 1));
    assign interval_done = unit_end && (units_q == dur - 3'd1);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            // An empty-queue write is taken straight to LOAD so the mark starts two cycles later.
            IDLE: if (!empty || push) state_d = LOAD;
            LOAD: begin
                pop   = 1'b1;
                pat_d = morse_lookup(head);
                idx_d = 2'd0;
                if (head <= MORSE_LAST_LETTER) state_d = MARK;
                else if (head == MORSE_SPACE)  state_d = WGAP;
                else                           state_d = IDLE;
            end
            MARK: if (interval_done)
                state_d = (({1'b0, idx_q} + 3'd1) < pat_q.len) ? SPACE : LGAP;
            SPACE: if (interval_done) begin
                idx_d   = idx_q + 2'd1;
                state_d = MARK;
            end
            LGAP, WGAP: if (interval_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_w) state_d = IDLE;

        cyc_d   = cyc_q;
        units_d = units_q;
        if (state_d != state_q || state_q == IDLE) begin
            cyc_d   = '0;
            units_d = '0;
        end else if (unit_end) begin
            cyc_d   = '0;
            units_d = units_q + 3'd1;
        end else begin
            cyc_d = cyc_q + CW'(1);
        end

        buzz_d = (state_d == MARK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            units_q <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            buzz_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            units_q <= units_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            buzz_q  <= buzz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign buzz       = buzz_q;
    assign overflow   = ovf_q;
    assign char_ready = !full;
    assign busy       = (state_q != IDLE) || !empty;
endmodule
